// File: rtl/cpu_run_pkg.sv
// Shared types and constants for the CPU run/step/halt sequencer.
package cpu_run_pkg;

   // Encoding is visible on the state output, so the values are fixed.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2,
      HALT = 2'd3
   } state_t;

   // 10 Hz free-run rate from a 50 MHz board clock.
   localparam int unsigned RUN_DIV_DEFAULT = 5_000_000;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced, already-synchronized button.
module btn_edge (
   input  logic clock,
   input  logic reset_N,
   input  logic i_btn,
   output logic o_rise
);

   logic r_btn_q;

   // Remember last cycle's button level.
   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) r_btn_q <= 1'b0;
      else          r_btn_q <= i_btn;
   end

   assign o_rise = i_btn & ~r_btn_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer: turns front-panel button edges into a registered
// one-cycle cpu_en pulse for the CPU shell and counts issued pulses.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | waiting for run or step; no pulses
//   RUN   | free-running, one pulse every RUN_DIV cycles
//   STEP  | alternating pulse/wait cycles until an instruction boundary
//   HALT  | program ended; only reset leaves this state
module cpu_run_ctrl
   import cpu_run_pkg::*;
#(
   parameter int unsigned RUN_DIV = RUN_DIV_DEFAULT,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clock,
   input  logic             reset_N,
   input  logic             run_btn,
   input  logic             step_btn,
   input  logic             stop_btn,
   input  logic             clocklevel,
   input  logic             endseq,
   output logic             cpu_en,
   output logic [1:0]       state,
   output logic             halted,
   output logic [CNT_W-1:0] cyc_cnt
);

   localparam int unsigned      PRE_W  = $clog2(RUN_DIV);
   localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(RUN_DIV - 1);

   logic             w_run_rise;
   logic             w_step_rise;
   logic             w_stop_rise;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [PRE_W-1:0] r_pre;
   logic [PRE_W-1:0] w_pre_nxt;
   logic             r_cpu_en;
   logic             w_cpu_en_nxt;
   logic             r_step_wait;
   logic             w_step_wait_nxt;
   logic             r_cl_q;
   logic             w_cl_q_nxt;
   logic [CNT_W-1:0] r_cyc_cnt;

   btn_edge u_run_edge (
      .clock   (clock),
      .reset_N (reset_N),
      .i_btn   (run_btn),
      .o_rise  (w_run_rise)
   );

   btn_edge u_step_edge (
      .clock   (clock),
      .reset_N (reset_N),
      .i_btn   (step_btn),
      .o_rise  (w_step_rise)
   );

   btn_edge u_stop_edge (
      .clock   (clock),
      .reset_N (reset_N),
      .i_btn   (stop_btn),
      .o_rise  (w_stop_rise)
   );

   // Next-state, prescaler and pulse decisions. cpu_en is decided here for
   // the following cycle, so any exit from RUN/STEP also suppresses the pulse.
   always_comb begin
      w_state_nxt     = r_state;
      w_pre_nxt       = '0;
      w_cpu_en_nxt    = 1'b0;
      w_step_wait_nxt = 1'b0;
      w_cl_q_nxt      = r_cl_q;
      case (r_state)
         IDLE: begin
            if (w_run_rise) begin
               w_state_nxt = RUN;
            end else if (w_step_rise) begin
               w_state_nxt  = STEP;
               w_cpu_en_nxt = 1'b1;
            end
         end
         RUN: begin
            if (endseq) begin
               w_state_nxt = HALT;
            end else if (w_stop_rise) begin
               w_state_nxt = IDLE;
            end else begin
               w_pre_nxt    = (r_pre == PRE_TC) ? '0 : r_pre + 1'b1;
               w_cpu_en_nxt = (r_pre == PRE_TC);
            end
         end
         STEP: begin
            // Pulse cycles capture the phase level the CPU showed before it advanced.
            if (!r_step_wait) w_cl_q_nxt = clocklevel;
            if (endseq) begin
               w_state_nxt = HALT;
            end else if (!r_step_wait) begin
               w_step_wait_nxt = 1'b1;
            end else if (r_cl_q && !clocklevel) begin
               w_state_nxt = IDLE;
            end else begin
               w_cpu_en_nxt = 1'b1;
            end
         end
         HALT: begin
            w_state_nxt = HALT;
         end
      endcase
   end

   // FSM, prescaler and pulse registers.
   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         r_state     <= IDLE;
         r_pre       <= '0;
         r_cpu_en    <= 1'b0;
         r_step_wait <= 1'b0;
         r_cl_q      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pre       <= w_pre_nxt;
         r_cpu_en    <= w_cpu_en_nxt;
         r_step_wait <= w_step_wait_nxt;
         r_cl_q      <= w_cl_q_nxt;
      end
   end

   // Saturating count of issued pulses for the display.
   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N)                            r_cyc_cnt <= '0;
      else if (r_cpu_en && (r_cyc_cnt != '1))  r_cyc_cnt <= r_cyc_cnt + 1'b1;
   end

   assign cpu_en  = r_cpu_en;
   assign state   = r_state;
   assign halted  = (r_state == HALT);
   assign cyc_cnt = r_cyc_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a small model of the CPU shell phase.
module tb_cpu_run_ctrl;

   logic        clock = 1'b0;
   logic        reset_N = 1'b1;
   logic        run_btn, step_btn, stop_btn, endseq;
   logic        clocklevel = 1'b0;
   logic        cpu_en;
   logic [1:0]  state;
   logic        halted;
   logic [15:0] cyc_cnt;

   logic        s_run, tie0;
   logic        s_cpu_en;
   logic [1:0]  s_state;
   logic        s_halted;
   logic [2:0]  s_cyc;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int pulse_cnt = 0;
   int pulse_cyc [16];
   int model_pulses = 0;
   int entry;
   int base;

   always #5 clock = ~clock;

   cpu_run_ctrl #(.RUN_DIV(4), .CNT_W(16)) u_dut (
      .clock      (clock),
      .reset_N    (reset_N),
      .run_btn    (run_btn),
      .step_btn   (step_btn),
      .stop_btn   (stop_btn),
      .clocklevel (clocklevel),
      .endseq     (endseq),
      .cpu_en     (cpu_en),
      .state      (state),
      .halted     (halted),
      .cyc_cnt    (cyc_cnt)
   );

   cpu_run_ctrl #(.RUN_DIV(2), .CNT_W(3)) u_sat (
      .clock      (clock),
      .reset_N    (reset_N),
      .run_btn    (s_run),
      .step_btn   (tie0),
      .stop_btn   (tie0),
      .clocklevel (tie0),
      .endseq     (tie0),
      .cpu_en     (s_cpu_en),
      .state      (s_state),
      .halted     (s_halted),
      .cyc_cnt    (s_cyc)
   );

   // Cycle index, advanced at each rising edge.
   always @(posedge clock) cyc = cyc + 1;

   // CPU shell model: phase goes high after pulse 1, low after pulse 3.
   always @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         model_pulses = 0;
         clocklevel  <= 1'b0;
      end else if (cpu_en) begin
         model_pulses = model_pulses + 1;
         clocklevel  <= (model_pulses == 1) || (model_pulses == 2);
      end
   end

   // Pulse log, sampled mid-cycle.
   always @(negedge clock or negedge reset_N) begin
      if (!reset_N) begin
         pulse_cnt = 0;
      end else if (cpu_en) begin
         if (pulse_cnt < 16) pulse_cyc[pulse_cnt] = cyc;
         pulse_cnt = pulse_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_N = 1'b0;
      #3;
      reset_N = 1'b1;
   endtask

   initial begin
      run_btn = 0; step_btn = 0; stop_btn = 0; endseq = 0; s_run = 0; tie0 = 0;

      // Reset values, then a quiet idle period.
      #2 reset_N = 1'b0;
      #1;
      chk("rst_state",  32'(state),   0);
      chk("rst_en",     32'(cpu_en),  0);
      chk("rst_halted", 32'(halted),  0);
      chk("rst_cyc",    32'(cyc_cnt), 0);
      @(posedge clock); #1 reset_N = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         chk("idle_state", 32'(state),  0);
         chk("idle_en",    32'(cpu_en), 0);
      end
      chk("idle_cyc", 32'(cyc_cnt), 0);

      // Free run at RUN_DIV=4, then stop.
      run_btn = 1; tick(1); run_btn = 0;
      entry = cyc;
      chk("run_enter", 32'(state), 1);
      tick(17);
      chk("run_pulses", 32'(pulse_cnt), 4);
      chk("run_first",  32'(pulse_cyc[0] - entry), 4);
      for (int i = 1; i < 4; i++) chk("run_spacing", 32'(pulse_cyc[i] - pulse_cyc[i-1]), 4);
      chk("run_cyc",    32'(cyc_cnt), 4);
      chk("run_halted", 32'(halted),  0);
      stop_btn = 1; tick(1); stop_btn = 0;
      chk("stop_state", 32'(state), 0);
      tick(10);
      chk("stop_pulses", 32'(pulse_cnt), 4);
      chk("stop_cyc",    32'(cyc_cnt),   4);

      // Asynchronous reset while a pulse is in flight.
      run_btn = 1; tick(1); run_btn = 0;
      tick(4);
      chk("mid_en_pre", 32'(cpu_en), 1);
      #2 reset_N = 1'b0;
      #1;
      chk("mid_rst_en",    32'(cpu_en),  0);
      chk("mid_rst_state", 32'(state),   0);
      chk("mid_rst_cyc",   32'(cyc_cnt), 0);
      @(posedge clock); #1 reset_N = 1'b1;

      // Single step with held button.
      step_btn = 1; tick(1);
      chk("step_enter", 32'(state),  2);
      chk("step_first", 32'(cpu_en), 1);
      tick(10);
      chk("step_pulses", 32'(pulse_cnt), 3);
      chk("step_period", 32'(pulse_cyc[1] - pulse_cyc[0]), 2);
      chk("step_state",  32'(state),   0);
      chk("step_cyc",    32'(cyc_cnt), 3);
      tick(5);
      chk("step_hold_pulses", 32'(pulse_cnt), 3);
      chk("step_hold_state",  32'(state),     0);
      step_btn = 0; tick(1);

      // endseq during a step pulse cycle.
      step_btn = 1; tick(1); step_btn = 0;
      base = pulse_cnt;
      endseq = 1; tick(1); endseq = 0;
      chk("step_end_state", 32'(state),  3);
      chk("step_end_en",    32'(cpu_en), 0);
      tick(5);
      chk("step_end_pulses", 32'(pulse_cnt - base), 1);

      // endseq together with stop, on the cycle a run pulse would be issued.
      do_reset();
      run_btn = 1; tick(1); run_btn = 0;
      tick(3);
      endseq = 1; stop_btn = 1; tick(1); endseq = 0; stop_btn = 0;
      chk("halt_state",  32'(state),  3);
      chk("halt_flag",   32'(halted), 1);
      chk("halt_en",     32'(cpu_en), 0);
      run_btn = 1; tick(1); run_btn = 0;
      step_btn = 1; tick(1); step_btn = 0;
      tick(10);
      chk("halt_stay_state",  32'(state),     3);
      chk("halt_stay_flag",   32'(halted),    1);
      chk("halt_stay_pulses", 32'(pulse_cnt), 0);
      chk("halt_stay_cyc",    32'(cyc_cnt),   0);

      // Run wins over step when both rise together.
      do_reset();
      run_btn = 1; step_btn = 1; tick(1); run_btn = 0; step_btn = 0;
      chk("both_state", 32'(state),  1);
      chk("both_en",    32'(cpu_en), 0);

      // Counter saturation on the narrow instance.
      do_reset();
      s_run = 1; tick(1); s_run = 0;
      chk("sat_enter", 32'(s_state), 1);
      tick(14);
      chk("sat_mid", 32'(s_cyc), 6);
      tick(16);
      chk("sat_full",  32'(s_cyc),   7);
      chk("sat_state", 32'(s_state), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
